// File: rtl/icache_fill_ctrl_pkg.sv
// rtl/icache_fill_ctrl_pkg.sv - shared fetch/fill constants, state encoding and helpers
package icache_fill_ctrl_pkg;

    // Fetch PC width shared by fetch and fill logic
    localparam int FETCH_SIZE_PC = 32;

    // A cache block is 16 bytes; PC[4] picks the even/odd bank
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int BANK_BIT          = 4;

    typedef enum logic [2:0] {
        FILL_IDLE  = 3'd0,
        FILL_REQ   = 3'd1,
        FILL_WAIT  = 3'd2,
        FILL_WRITE = 3'd3,
        FILL_DRAIN = 3'd4
    } fill_state_e;

    // Beat counter width: clog2(beats), never less than one bit
    function automatic int beat_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/icache_fill_ctrl_if.sv
// rtl/icache_fill_ctrl_if.sv - fetch, memory and fill signals of the icache fill controller
interface icache_fill_ctrl_if
    import icache_fill_ctrl_pkg::*;
#(
    parameter int SIZE_PC    = FETCH_SIZE_PC,
    parameter int BEAT_W     = 64,
    parameter int BEATS      = 2,
    parameter int INDEX_BITS = 5
);
    // Fetch side
    logic                               miss_i;
    logic [SIZE_PC-1:0]                 missPc_i;
    logic                               flush_i;
    logic                               stall_o;

    // Next memory level
    logic                               memReq_o;
    logic [SIZE_PC-1:0]                 memReqAddr_o;
    logic                               memReqAck_i;
    logic                               memRespValid_i;
    logic [BEAT_W-1:0]                  memRespData_i;

    // Cache write port
    logic                               fillValid_o;
    logic                               fillBank_o;
    logic [INDEX_BITS-1:0]              fillIndex_o;
    logic [SIZE_PC-INDEX_BITS-6:0]      fillTag_o;
    logic [BEATS*BEAT_W-1:0]            fillData_o;

    // Fill controller side
    modport master (
        input  miss_i, missPc_i, flush_i,
        input  memReqAck_i, memRespValid_i, memRespData_i,
        output stall_o, memReq_o, memReqAddr_o,
        output fillValid_o, fillBank_o, fillIndex_o, fillTag_o, fillData_o
    );

    // Fetch stage / memory / cache side
    modport slave (
        output miss_i, missPc_i, flush_i,
        output memReqAck_i, memRespValid_i, memRespData_i,
        input  stall_o, memReq_o, memReqAddr_o,
        input  fillValid_o, fillBank_o, fillIndex_o, fillTag_o, fillData_o
    );

endinterface

// File: rtl/icache_fill_ctrl_fill_beat_buffer.sv
// rtl/icache_fill_ctrl_fill_beat_buffer.sv - beat counter and cache block assembly register
module fill_beat_buffer
    import icache_fill_ctrl_pkg::*;
#(
    parameter int BEAT_W = 64,
    parameter int BEATS  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [BEAT_W-1:0]       data,
    output logic                    last,
    output logic [BEATS*BEAT_W-1:0] block
);
    localparam int CNT_W = beat_cnt_w(BEATS);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BEATS*BEAT_W-1:0] block_q, block_d;

    // Place the incoming beat at the slot given by the counter; counter saturates on the last slot
    always_comb begin
        cnt_d   = cnt_q;
        block_d = block_q;
        if (clear) begin
            cnt_d = '0;
        end else if (wr_en) begin
            for (int i = 0; i < BEATS; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    block_d[i*BEAT_W +: BEAT_W] = data;
                end
            end
            if (cnt_q != LAST_SLOT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter and block registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            block_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            block_q <= block_d;
        end
    end

    assign last  = (cnt_q == LAST_SLOT);
    assign block = block_q;

endmodule

// File: rtl/icache_fill_ctrl.sv
// rtl/icache_fill_ctrl.sv - icache miss sequencing: request, beat collection, bank write, flush drain
module icache_fill_ctrl
    import icache_fill_ctrl_pkg::*;
#(
    parameter int SIZE_PC    = FETCH_SIZE_PC,
    parameter int BEAT_W     = 64,
    parameter int BEATS      = 2,
    parameter int INDEX_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    icache_fill_ctrl_if.master  bus
);
    // Only the block address of the missing PC is kept; the offset bits are always zero on the bus
    localparam int BLK_W   = SIZE_PC - BLOCK_OFFSET_BITS;
    localparam int BANK_LO = BANK_BIT - BLOCK_OFFSET_BITS;

    fill_state_e            state_q, state_d;
    logic [BLK_W-1:0]       blk_q, blk_d;

    logic                   beat_clear;
    logic                   beat_we;
    logic                   beat_last;
    logic [BEATS*BEAT_W-1:0] block;

    fill_beat_buffer #(
        .BEAT_W (BEAT_W),
        .BEATS  (BEATS)
    ) u_beat_buf (
        .clk   (clk),
        .reset (reset),
        .clear (beat_clear),
        .wr_en (beat_we),
        .data  (bus.memRespData_i),
        .last  (beat_last),
        .block (block)
    );

    // Next state, PC latch and beat buffer control
    always_comb begin
        state_d    = state_q;
        blk_d      = blk_q;
        beat_clear = 1'b0;
        beat_we    = 1'b0;
        case (state_q)
            FILL_IDLE: begin
                if (bus.miss_i && !bus.flush_i) begin
                    blk_d      = bus.missPc_i[SIZE_PC-1:BLOCK_OFFSET_BITS];
                    beat_clear = 1'b1;
                    state_d    = FILL_REQ;
                end
            end
            FILL_REQ: begin
                // An ack in the flush cycle means a response is coming and must be drained
                if (bus.memReqAck_i) begin
                    state_d = bus.flush_i ? FILL_DRAIN : FILL_WAIT;
                end else if (bus.flush_i) begin
                    state_d = FILL_IDLE;
                end
            end
            FILL_WAIT: begin
                beat_we = bus.memRespValid_i;
                if (bus.flush_i) begin
                    // Flush on the last beat leaves nothing to drain
                    state_d = (bus.memRespValid_i && beat_last) ? FILL_IDLE : FILL_DRAIN;
                end else if (bus.memRespValid_i && beat_last) begin
                    state_d = FILL_WRITE;
                end
            end
            FILL_WRITE: begin
                state_d = FILL_IDLE;
            end
            FILL_DRAIN: begin
                beat_we = bus.memRespValid_i;
                if (bus.memRespValid_i && beat_last) begin
                    state_d = FILL_IDLE;
                end
            end
            default: begin
                state_d = FILL_IDLE;
            end
        endcase
    end

    // State and latched block address
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL_IDLE;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
        end
    end

    assign bus.stall_o      = (state_q != FILL_IDLE);
    assign bus.memReq_o     = (state_q == FILL_REQ);
    assign bus.memReqAddr_o = {blk_q, {BLOCK_OFFSET_BITS{1'b0}}};
    assign bus.fillValid_o  = (state_q == FILL_WRITE);
    assign bus.fillBank_o   = blk_q[BANK_LO];
    assign bus.fillIndex_o  = blk_q[BANK_LO+INDEX_BITS:BANK_LO+1];
    assign bus.fillTag_o    = blk_q[BLK_W-1:BANK_LO+INDEX_BITS+1];
    assign bus.fillData_o   = block;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb/tb_icache_fill_ctrl.sv - directed self-checking bench for icache_fill_ctrl
module tb_icache_fill_ctrl;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    int   fills;

    icache_fill_ctrl_if bus ();

    icache_fill_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count write strobes away from the active edge
    always @(negedge clk) begin
        if (bus.fillValid_o === 1'b1) fills++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        fills  = 0;
        reset  = 1'b1;
        bus.miss_i         = 1'b0;
        bus.missPc_i       = '0;
        bus.flush_i        = 1'b0;
        bus.memReqAck_i    = 1'b0;
        bus.memRespValid_i = 1'b0;
        bus.memRespData_i  = '0;
        step();
        step();

        // Reset state
        chk("rst_memReq", 128'(bus.memReq_o), 128'd0);
        chk("rst_addr", 128'(bus.memReqAddr_o), 128'd0);
        chk("rst_fillValid", 128'(bus.fillValid_o), 128'd0);
        chk("rst_stall", 128'(bus.stall_o), 128'd0);
        chk("rst_data", 128'(bus.fillData_o), 128'd0);
        reset = 1'b0;
        step();

        // Basic fill, odd bank
        bus.miss_i = 1'b1; bus.missPc_i = 32'h0000_1234;
        step();
        bus.miss_i = 1'b0; bus.missPc_i = '0;
        chk("t1_memReq", 128'(bus.memReq_o), 128'd1);
        chk("t1_addr", 128'(bus.memReqAddr_o), 128'h1230);
        chk("t1_stall", 128'(bus.stall_o), 128'd1);
        bus.memReqAck_i = 1'b1;
        step();
        bus.memReqAck_i = 1'b0;
        chk("t1_wait_memReq", 128'(bus.memReq_o), 128'd0);
        chk("t1_wait_stall", 128'(bus.stall_o), 128'd1);
        bus.memRespValid_i = 1'b1; bus.memRespData_i = 64'hAAAA_AAAA_AAAA_AAAA;
        step();
        bus.memRespData_i = 64'hBBBB_BBBB_BBBB_BBBB;
        step();
        bus.memRespValid_i = 1'b0; bus.memRespData_i = '0;
        chk("t1_fillValid", 128'(bus.fillValid_o), 128'd1);
        chk("t1_bank", 128'(bus.fillBank_o), 128'd1);
        chk("t1_index", 128'(bus.fillIndex_o), 128'h11);
        chk("t1_tag", 128'(bus.fillTag_o), 128'h4);
        chk("t1_data", 128'(bus.fillData_o), {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
        step();
        chk("t1_after_fillValid", 128'(bus.fillValid_o), 128'd0);
        chk("t1_after_stall", 128'(bus.stall_o), 128'd0);
        chk("t1_pulses", 128'(fills), 128'd1);

        // Even bank with delayed ack
        bus.miss_i = 1'b1; bus.missPc_i = 32'h0000_1008;
        step();
        bus.miss_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t2_memReq_%0d", i), 128'(bus.memReq_o), 128'd1);
            chk($sformatf("t2_addr_%0d", i), 128'(bus.memReqAddr_o), 128'h1000);
            if (i == 5) bus.memReqAck_i = 1'b1;
            step();
        end
        bus.memReqAck_i = 1'b0;
        chk("t2_wait_memReq", 128'(bus.memReq_o), 128'd0);
        bus.memRespValid_i = 1'b1; bus.memRespData_i = 64'h1111_1111_1111_1111;
        step();
        bus.memRespData_i = 64'h2222_2222_2222_2222;
        step();
        bus.memRespValid_i = 1'b0;
        chk("t2_fillValid", 128'(bus.fillValid_o), 128'd1);
        chk("t2_bank", 128'(bus.fillBank_o), 128'd0);
        chk("t2_index", 128'(bus.fillIndex_o), 128'h0);
        chk("t2_tag", 128'(bus.fillTag_o), 128'h4);
        chk("t2_data", 128'(bus.fillData_o), {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        step();
        chk("t2_pulses", 128'(fills), 128'd2);

        // Miss together with flush in IDLE is ignored
        bus.miss_i = 1'b1; bus.flush_i = 1'b1; bus.missPc_i = 32'h0000_9990;
        step();
        bus.miss_i = 1'b0; bus.flush_i = 1'b0;
        chk("t3_missflush_stall", 128'(bus.stall_o), 128'd0);
        chk("t3_missflush_memReq", 128'(bus.memReq_o), 128'd0);

        // Flush two cycles into REQ without ack
        bus.miss_i = 1'b1; bus.missPc_i = 32'h0000_3000;
        step();
        bus.miss_i = 1'b0;
        step();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("t3_flush_memReq", 128'(bus.memReq_o), 128'd0);
        chk("t3_flush_stall", 128'(bus.stall_o), 128'd0);
        step();
        chk("t3_pulses", 128'(fills), 128'd2);

        // Flush in WAIT after beat 0, late beat 1 drained
        bus.miss_i = 1'b1; bus.missPc_i = 32'h0000_4050;
        step();
        bus.miss_i = 1'b0; bus.memReqAck_i = 1'b1;
        step();
        bus.memReqAck_i = 1'b0;
        bus.memRespValid_i = 1'b1; bus.memRespData_i = 64'h3333_3333_3333_3333;
        step();
        bus.memRespValid_i = 1'b0; bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("t4_drain_stall", 128'(bus.stall_o), 128'd1);
        chk("t4_drain_memReq", 128'(bus.memReq_o), 128'd0);
        step();
        step();
        chk("t4_drain_stall2", 128'(bus.stall_o), 128'd1);
        bus.memRespValid_i = 1'b1; bus.memRespData_i = 64'h4444_4444_4444_4444;
        step();
        bus.memRespValid_i = 1'b0;
        chk("t4_idle_stall", 128'(bus.stall_o), 128'd0);
        chk("t4_pulses", 128'(fills), 128'd2);

        // Fresh miss after the drain proceeds normally
        bus.miss_i = 1'b1; bus.missPc_i = 32'h0000_5010;
        step();
        bus.miss_i = 1'b0;
        chk("t4b_addr", 128'(bus.memReqAddr_o), 128'h5010);
        bus.memReqAck_i = 1'b1;
        step();
        bus.memReqAck_i = 1'b0;
        bus.memRespValid_i = 1'b1; bus.memRespData_i = 64'h5555_5555_5555_5555;
        step();
        bus.memRespData_i = 64'h6666_6666_6666_6666;
        step();
        bus.memRespValid_i = 1'b0;
        chk("t4b_fillValid", 128'(bus.fillValid_o), 128'd1);
        chk("t4b_bank", 128'(bus.fillBank_o), 128'd1);
        chk("t4b_index", 128'(bus.fillIndex_o), 128'h0);
        chk("t4b_tag", 128'(bus.fillTag_o), 128'h14);
        chk("t4b_data", 128'(bus.fillData_o), {64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
        step();
        chk("t4b_pulses", 128'(fills), 128'd3);

        // Miss while busy is ignored
        bus.miss_i = 1'b1; bus.missPc_i = 32'h0000_6660;
        step();
        bus.miss_i = 1'b0; bus.memReqAck_i = 1'b1;
        step();
        bus.memReqAck_i = 1'b0;
        bus.miss_i = 1'b1; bus.missPc_i = 32'h0000_2000;
        step();
        bus.miss_i = 1'b0;
        bus.memRespValid_i = 1'b1; bus.memRespData_i = 64'h7777_7777_7777_7777;
        step();
        bus.memRespData_i = 64'h8888_8888_8888_8888;
        step();
        bus.memRespValid_i = 1'b0;
        chk("t5_fillValid", 128'(bus.fillValid_o), 128'd1);
        chk("t5_addr", 128'(bus.memReqAddr_o), 128'h6660);
        chk("t5_bank", 128'(bus.fillBank_o), 128'd0);
        chk("t5_index", 128'(bus.fillIndex_o), 128'h13);
        chk("t5_tag", 128'(bus.fillTag_o), 128'h19);
        chk("t5_data", 128'(bus.fillData_o), {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777});
        step();
        chk("t5_idle_stall", 128'(bus.stall_o), 128'd0);
        chk("t5_idle_memReq", 128'(bus.memReq_o), 128'd0);
        chk("t5_pulses", 128'(fills), 128'd4);

        // Flush together with ack: both beats drained
        bus.miss_i = 1'b1; bus.missPc_i = 32'h0000_8000;
        step();
        bus.miss_i = 1'b0; bus.memReqAck_i = 1'b1; bus.flush_i = 1'b1;
        step();
        bus.memReqAck_i = 1'b0; bus.flush_i = 1'b0;
        chk("t7_drain_stall", 128'(bus.stall_o), 128'd1);
        chk("t7_drain_memReq", 128'(bus.memReq_o), 128'd0);
        bus.memRespValid_i = 1'b1; bus.memRespData_i = 64'h1;
        step();
        chk("t7_drain_stall1", 128'(bus.stall_o), 128'd1);
        bus.memRespData_i = 64'h2;
        step();
        bus.memRespValid_i = 1'b0;
        chk("t7_idle_stall", 128'(bus.stall_o), 128'd0);
        chk("t7_pulses", 128'(fills), 128'd4);

        // Reset in WAIT with beats still arriving
        bus.miss_i = 1'b1; bus.missPc_i = 32'h0000_7770;
        step();
        bus.miss_i = 1'b0; bus.memReqAck_i = 1'b1;
        step();
        bus.memReqAck_i = 1'b0;
        bus.memRespValid_i = 1'b1; bus.memRespData_i = 64'h9999_9999_9999_9999;
        step();
        reset = 1'b1; bus.memRespData_i = 64'hAAAA_0000_AAAA_0000;
        step();
        chk("t6_memReq", 128'(bus.memReq_o), 128'd0);
        chk("t6_addr", 128'(bus.memReqAddr_o), 128'd0);
        chk("t6_fillValid", 128'(bus.fillValid_o), 128'd0);
        chk("t6_bank", 128'(bus.fillBank_o), 128'd0);
        chk("t6_index", 128'(bus.fillIndex_o), 128'd0);
        chk("t6_tag", 128'(bus.fillTag_o), 128'd0);
        chk("t6_data", 128'(bus.fillData_o), 128'd0);
        chk("t6_stall", 128'(bus.stall_o), 128'd0);
        reset = 1'b0;
        step();
        bus.memRespValid_i = 1'b0;
        chk("t6_stray_stall", 128'(bus.stall_o), 128'd0);

        // Normal fill after the reset
        bus.miss_i = 1'b1; bus.missPc_i = 32'h0000_1234;
        step();
        bus.miss_i = 1'b0; bus.memReqAck_i = 1'b1;
        step();
        bus.memReqAck_i = 1'b0;
        bus.memRespValid_i = 1'b1; bus.memRespData_i = 64'hCCCC_CCCC_CCCC_CCCC;
        step();
        bus.memRespData_i = 64'hDDDD_DDDD_DDDD_DDDD;
        step();
        bus.memRespValid_i = 1'b0;
        chk("t6b_fillValid", 128'(bus.fillValid_o), 128'd1);
        chk("t6b_data", 128'(bus.fillData_o), {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC});
        step();
        chk("t6b_pulses", 128'(fills), 128'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
